// File: rtl/lock_scheduler.sv
// lock_scheduler: round-robin canal lock sequencer, outer/inner queues
// Define LOCK_SCHED_TIMEOUT_EN to build the WAIT_ENTER timeout/abort path
module lock_scheduler #(
  parameter int ENTRY_TIMEOUT = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_outer,
  input  logic req_inner,
  input  logic match_outer,
  input  logic match_inner,
  input  logic outer_closed,
  input  logic inner_closed,
  input  logic gondola_in,
  input  logic gondola_out,
  output logic fill,
  output logic drain,
  output logic open_outer,
  output logic open_inner,
  output logic grant_outer,
  output logic grant_inner,
  output logic busy,
  output logic timeout
);

  if (ENTRY_TIMEOUT < 1 || ENTRY_TIMEOUT > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("ENTRY_TIMEOUT out of range for CNT_W");
  end

  typedef enum logic [3:0] {
    IDLE, ALIGN_IN, OPEN_IN, WAIT_ENTER, CLOSE_IN,
    ALIGN_OUT, OPEN_OUT, WAIT_EXIT, CLOSE_OUT, ABORT
  } state_t;

  state_t state, state_d;
  logic dir, dir_d;
  logic last, last_d;
  logic fill_d, drain_d, timeout_d;
  logic open_outer_d, open_inner_d;
  logic grant_outer_d, grant_inner_d, busy_d;
  logic ent_open, ext_open;

  // dir/last: 1 = outer side, 0 = inner side
  logic ent_match, ext_match;
  logic ent_closed, ext_closed, both_closed;

  assign ent_match   = dir ? match_outer : match_inner;
  assign ext_match   = dir ? match_inner : match_outer;
  assign ent_closed  = dir ? outer_closed : inner_closed;
  assign ext_closed  = dir ? inner_closed : outer_closed;
  assign both_closed = outer_closed & inner_closed;

`ifdef LOCK_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ENTRY_TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;

  // entry wait counter: zero outside WAIT_ENTER, saturating inside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state != WAIT_ENTER) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // next state and next registered outputs
  always_comb begin
    state_d   = state;
    dir_d     = dir;
    last_d    = last;
    fill_d    = 1'b0;
    drain_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_outer | req_inner) begin
          dir_d   = (req_outer & req_inner) ? ~last : req_outer;
          state_d = ALIGN_IN;
        end
      end
      ALIGN_IN: begin
        if (both_closed) begin
          if (ent_match) begin
            state_d = OPEN_IN;
          end else begin
            fill_d  = dir;
            drain_d = ~dir;
          end
        end
      end
      OPEN_IN: begin
        if (!ent_closed) state_d = WAIT_ENTER;
      end
      WAIT_ENTER: begin
        if (gondola_in) begin
          state_d = CLOSE_IN;
        end
`ifdef LOCK_SCHED_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
`endif
      end
      CLOSE_IN: begin
        if (ent_closed) state_d = ALIGN_OUT;
      end
      ALIGN_OUT: begin
        if (both_closed) begin
          if (ext_match) begin
            state_d = OPEN_OUT;
          end else begin
            fill_d  = ~dir;
            drain_d = dir;
          end
        end
      end
      OPEN_OUT: begin
        if (!ext_closed) state_d = WAIT_EXIT;
      end
      WAIT_EXIT: begin
        if (gondola_out) state_d = CLOSE_OUT;
      end
      CLOSE_OUT: begin
        if (ext_closed) begin
          last_d  = dir;
          state_d = IDLE;
        end
      end
`ifdef LOCK_SCHED_TIMEOUT_EN
      ABORT: begin
        if (ent_closed) begin
          last_d  = dir;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    ent_open      = state_d inside {OPEN_IN, WAIT_ENTER};
    ext_open      = state_d inside {OPEN_OUT, WAIT_EXIT};
    open_outer_d  = (dir_d & ent_open) | (~dir_d & ext_open);
    open_inner_d  = (~dir_d & ent_open) | (dir_d & ext_open);
    busy_d        = state_d != IDLE;
    grant_outer_d = busy_d & dir_d;
    grant_inner_d = busy_d & ~dir_d;
  end

  // state and Moore output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= 1'b0;
      last        <= 1'b0;
      fill        <= 1'b0;
      drain       <= 1'b0;
      open_outer  <= 1'b0;
      open_inner  <= 1'b0;
      grant_outer <= 1'b0;
      grant_inner <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      dir         <= dir_d;
      last        <= last_d;
      fill        <= fill_d;
      drain       <= drain_d;
      open_outer  <= open_outer_d;
      open_inner  <= open_inner_d;
      grant_outer <= grant_outer_d;
      grant_inner <= grant_inner_d;
      busy        <= busy_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_lock_scheduler.sv
// tb_lock_scheduler: directed checks of lock_scheduler
// Water level and port models stand in for the lock datapath
module tb_lock_scheduler;

  logic clk;
  logic rst;
  logic req_outer, req_inner;
  logic match_outer, match_inner;
  logic outer_closed, inner_closed;
  logic gondola_in, gondola_out;
  logic fill, drain, open_outer, open_inner;
  logic grant_outer, grant_inner, busy, timeout;

  int checks = 0;
  int fails = 0;
  int inv_bad = 0;

  int   level;
  logic oc_r, ic_r;
  logic stuck_inner;

  lock_scheduler #(.ENTRY_TIMEOUT(10), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_outer(req_outer), .req_inner(req_inner),
    .match_outer(match_outer), .match_inner(match_inner),
    .outer_closed(outer_closed), .inner_closed(inner_closed),
    .gondola_in(gondola_in), .gondola_out(gondola_out),
    .fill(fill), .drain(drain),
    .open_outer(open_outer), .open_inner(open_inner),
    .grant_outer(grant_outer), .grant_inner(grant_inner),
    .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // level sensor reports the level reached at the end of the current cycle
  assign match_outer  = (level + (fill ? 7 : 0)) >= 73;
  assign match_inner  = (level - (drain ? 8 : 0)) <= 49;
  assign outer_closed = oc_r;
  assign inner_closed = ic_r & ~stuck_inner;

  // lock datapath: +7 per fill cycle, -8 per drain cycle, ports lag 1 cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 52;
      oc_r  <= 1'b1;
      ic_r  <= 1'b1;
    end else begin
      if (fill)  level <= level + 7;
      if (drain) level <= level - 8;
      oc_r <= ~open_outer;
      ic_r <= ~open_inner;
    end
  end

  // safety invariants watched over the whole run
  always @(negedge clk) begin
    if (!rst) begin
      if (fill & drain) inv_bad <= inv_bad + 1;
      if (open_outer & open_inner) inv_bad <= inv_bad + 1;
      if (grant_outer & grant_inner) inv_bad <= inv_bad + 1;
      if ((fill | drain) & ~(outer_closed & inner_closed))
        inv_bad <= inv_bad + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return grant_outer;
      1: return grant_inner;
      2: return open_outer;
      3: return open_inner;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, input string nm);
    int n;
    n = 0;
    while (sel(w) !== v && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (sel(w) !== v) begin
      fails++;
      $display("FAIL wait_%s: got %b want %b after %0d cycles",
               nm, sel(w), v, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_outer = 1'b0;
    req_inner = 1'b0;
    gondola_in = 1'b0;
    gondola_out = 1'b0;
    stuck_inner = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_in();
    gondola_in = 1'b1;
    step();
    gondola_in = 1'b0;
  endtask

  task automatic pulse_out();
    gondola_out = 1'b1;
    step();
    gondola_out = 1'b0;
  endtask

  task automatic drive_to_exit_open(input logic outer);
    wait_sig(outer ? 2 : 3, 1'b1, "entry_open");
    step();
    step();
    pulse_in();
    wait_sig(outer ? 3 : 2, 1'b1, "exit_open");
  endtask

  task automatic finish_exit();
    step();
    step();
    pulse_out();
    wait_sig(4, 1'b0, "idle");
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rst = 1'b1;
    #2;
    o = {fill, drain, open_outer, open_inner,
         grant_outer, grant_inner, busy, timeout};
    checks++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL reset_hold: got %h want 00", o);
    end
    do_reset();
    step();
    o = {fill, drain, open_outer, open_inner,
         grant_outer, grant_inner, busy, timeout};
    checks++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: got %h want 00", o);
    end
  endtask

  task automatic test_passage();
    int nfill, ndrain, gdrop;
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    checks++;
    if ({grant_outer, grant_inner, busy} !== 3'b101) begin
      fails++;
      $display("FAIL pass_grant: got %b want 101",
               {grant_outer, grant_inner, busy});
    end
    nfill = 0; ndrain = 0; gdrop = 0;
    for (int i = 0; i < 20 && open_outer !== 1'b1; i++) begin
      if (fill) nfill++;
      if (drain) ndrain++;
      if (!grant_outer) gdrop++;
      step();
    end
    checks++;
    if (nfill != 3 || ndrain != 0 || open_outer !== 1'b1) begin
      fails++;
      $display("FAIL pass_fill: got fill=%0d drain=%0d open=%b want 3 0 1",
               nfill, ndrain, open_outer);
    end
    gondola_in = 1'b1;
    step();
    gondola_in = 1'b0;
    step();
    checks++;
    if (open_outer !== 1'b1) begin
      fails++;
      $display("FAIL pass_early_in: got open_outer=%b want 1", open_outer);
    end
    pulse_in();
    checks++;
    if ({open_outer, grant_outer} !== 2'b01) begin
      fails++;
      $display("FAIL pass_close_in: got %b want 01",
               {open_outer, grant_outer});
    end
    nfill = 0; ndrain = 0;
    for (int i = 0; i < 20 && open_inner !== 1'b1; i++) begin
      if (fill) nfill++;
      if (drain) ndrain++;
      if (!grant_outer) gdrop++;
      step();
    end
    checks++;
    if (nfill != 0 || ndrain != 3 || open_inner !== 1'b1) begin
      fails++;
      $display("FAIL pass_drain: got fill=%0d drain=%0d open=%b want 0 3 1",
               nfill, ndrain, open_inner);
    end
    checks++;
    if (gdrop != 0) begin
      fails++;
      $display("FAIL pass_grant_hold: got %0d drops want 0", gdrop);
    end
    step();
    step();
    pulse_out();
    checks++;
    if ({open_inner, grant_outer} !== 2'b01) begin
      fails++;
      $display("FAIL pass_close_out: got %b want 01",
               {open_inner, grant_outer});
    end
    wait_sig(4, 1'b0, "pass_idle");
    checks++;
    if ({grant_outer, grant_inner} !== 2'b00) begin
      fails++;
      $display("FAIL pass_grant_clr: got %b want 00",
               {grant_outer, grant_inner});
    end
  endtask

  task automatic test_reset_mid_exit();
    logic [7:0] o;
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    drive_to_exit_open(1'b1);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    o = {fill, drain, open_outer, open_inner,
         grant_outer, grant_inner, busy, timeout};
    checks++;
    if (o !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_exit: got %h want 00", o);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_after: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_outer;
    do_reset();
    req_outer = 1'b1;
    req_inner = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_outer = (k % 2) == 0;
      wait_sig(4, 1'b1, "rr_busy");
      checks++;
      if ({grant_outer, grant_inner} !== {exp_outer, ~exp_outer}) begin
        fails++;
        $display("FAIL rr_grant_%0d: got %b want %b", k,
                 {grant_outer, grant_inner}, {exp_outer, ~exp_outer});
      end
      drive_to_exit_open(exp_outer);
      finish_exit();
    end
    req_outer = 1'b0;
    req_inner = 1'b0;
  endtask

`ifdef LOCK_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    wait_sig(2, 1'b1, "to_open");
    repeat (11) step();
    checks++;
    if ({timeout, open_outer} !== 2'b01) begin
      fails++;
      $display("FAIL to_before: got %b want 01", {timeout, open_outer});
    end
    step();
    checks++;
    if ({timeout, open_outer} !== 2'b10) begin
      fails++;
      $display("FAIL to_pulse: got %b want 10", {timeout, open_outer});
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL to_once: got %b want 0", timeout);
    end
    wait_sig(4, 1'b0, "to_idle");
    req_outer = 1'b1;
    req_inner = 1'b1;
    wait_sig(4, 1'b1, "to_next");
    req_outer = 1'b0;
    req_inner = 1'b0;
    checks++;
    if ({grant_outer, grant_inner} !== 2'b01) begin
      fails++;
      $display("FAIL to_next_grant: got %b want 01",
               {grant_outer, grant_inner});
    end
  endtask

  task automatic test_in_at_expiry();
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    wait_sig(2, 1'b1, "exp_open");
    repeat (11) step();
    pulse_in();
    checks++;
    if ({timeout, open_outer, grant_outer} !== 3'b001) begin
      fails++;
      $display("FAIL exp_close_in: got %b want 001",
               {timeout, open_outer, grant_outer});
    end
    step();
    checks++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL exp_no_to: got %b want 0", timeout);
    end
    wait_sig(3, 1'b1, "exp_exit_open");
    finish_exit();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    wait_sig(2, 1'b1, "nt_open");
    repeat (30) step();
    checks++;
    if ({timeout, open_outer, busy} !== 3'b011) begin
      fails++;
      $display("FAIL nt_wait: got %b want 011",
               {timeout, open_outer, busy});
    end
    pulse_in();
    wait_sig(3, 1'b1, "nt_exit_open");
    finish_exit();
  endtask
`endif

  task automatic test_port_stuck();
    int bad, ndrain;
    do_reset();
    req_outer = 1'b1;
    step();
    req_outer = 1'b0;
    wait_sig(2, 1'b1, "st_open");
    step();
    step();
    stuck_inner = 1'b1;
    pulse_in();
    bad = 0;
    repeat (8) begin
      step();
      if (fill | drain | open_inner | open_outer) bad++;
    end
    checks++;
    if (bad != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL st_hold: got bad=%0d busy=%b want 0 1", bad, busy);
    end
    stuck_inner = 1'b0;
    ndrain = 0;
    for (int i = 0; i < 20 && open_inner !== 1'b1; i++) begin
      if (drain) ndrain++;
      step();
    end
    checks++;
    if (ndrain != 3 || open_inner !== 1'b1) begin
      fails++;
      $display("FAIL st_release: got drain=%0d open=%b want 3 1",
               ndrain, open_inner);
    end
    finish_exit();
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_bad != 0) begin
      fails++;
      $display("FAIL invariants: got %0d violations want 0", inv_bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_outer = 1'b0;
    req_inner = 1'b0;
    gondola_in = 1'b0;
    gondola_out = 1'b0;
    stuck_inner = 1'b0;
    test_reset();
    test_passage();
    test_reset_mid_exit();
    test_round_robin();
`ifdef LOCK_SCHED_TIMEOUT_EN
    test_timeout();
    test_in_at_expiry();
`else
    test_no_timeout();
`endif
    test_port_stuck();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
